// File: rtl/lockin_pkg.sv
// Shared sizing for the lock-in sample buffer and its controller.
// Keep these in step with lockin_controller.
package lockin_pkg;
  localparam int BUFFER_DEPTH = 512;
  localparam int DATA_WIDTH   = 24;
  localparam int ADDR_W       = $clog2(BUFFER_DEPTH);
endpackage

// File: rtl/lockin_dp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// The array has no reset so it maps onto block RAM; only the read register resets.
module lockin_dp_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 24,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/lockin_sample_buffer.sv
// Ping-pong capture buffer: fills one bank while the controller reads the other,
// swapping banks and pulsing buffer_ready each time the write bank fills.
module lockin_sample_buffer
  import lockin_pkg::*;
#(
  parameter int BUFFER_DEPTH = lockin_pkg::BUFFER_DEPTH,
  parameter int DATA_WIDTH   = lockin_pkg::DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            capture_en,
  input  logic [DATA_WIDTH-1:0]           sample_in,
  input  logic                            sample_valid,
  input  logic                            reader_busy,
  input  logic                            overrun_clear,
  output logic                            buffer_ready,
  input  logic [$clog2(BUFFER_DEPTH)-1:0] buffer_addr,
  output logic [DATA_WIDTH-1:0]           buffer_data,
  output logic [$clog2(BUFFER_DEPTH):0]   fill_count,
  output logic                            read_bank,
  output logic                            overrun
);
  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam logic [AW-1:0] LAST = AW'(BUFFER_DEPTH - 1);

  logic [AW-1:0] r_wr_ptr;
  logic          r_read_bank;
  logic          r_cap_en_q;
  logic          r_ready;
  logic          r_overrun;

  logic          w_wr;
  logic          w_swap;
  logic          w_cap_fall;

  assign w_wr       = capture_en & sample_valid;
  assign w_swap     = w_wr & (r_wr_ptr == LAST);
  assign w_cap_fall = r_cap_en_q & ~capture_en;

  // Dropping capture_en abandons the partial bank; the pointer wraps by width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_read_bank <= 1'b1;
      r_cap_en_q  <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_cap_en_q <= capture_en;
      r_ready    <= w_swap;
      if (w_cap_fall)  r_wr_ptr <= '0;
      else if (w_wr)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_swap)      r_read_bank <= ~r_read_bank;
    end
  end

  // A swap into a busy reader flags overrun; set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_overrun <= 1'b0;
    else if (w_swap && reader_busy) r_overrun <= 1'b1;
    else if (overrun_clear)         r_overrun <= 1'b0;
  end

  lockin_dp_ram #(
    .DEPTH (2 * BUFFER_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst       (reset),
    .i_wr_en   (w_wr),
    .i_wr_addr ({~r_read_bank, r_wr_ptr}),
    .i_wr_data (sample_in),
    .i_rd_addr ({r_read_bank, buffer_addr}),
    .o_rd_data (buffer_data)
  );

  assign buffer_ready = r_ready;
  assign fill_count   = {1'b0, r_wr_ptr};
  assign read_bank    = r_read_bank;
  assign overrun      = r_overrun;
endmodule
